// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with a 4-byte command-frame parser (sync, command, data, XOR checksum).
// The serial input passes through a two-flop synchroniser; the bit FSM and the frame parser
// each register every output, so UART_RX has no combinational path to any port.
module uart_cmd_rx #(
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BAUD         = 115200,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 40
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       UART_RX,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_data,
    output logic       err_framing,
    output logic       err_checksum
);

    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} bit_state_t;
    typedef enum logic [1:0] {P_SYNC, P_CMD, P_DATA, P_SUM} parse_state_t;

    logic rx_meta, rx_s;

    bit_state_t       bit_state, bit_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic             byte_valid_next, err_framing_next;
    logic [7:0]       byte_data_next;

    parse_state_t    p_state, p_next;
    logic [7:0]      cmd_tmp, cmd_tmp_next, data_tmp, data_tmp_next;
    logic [7:0]      cmd_code_next, cmd_data_next;
    logic            cmd_valid_next, err_checksum_next;
    logic [TO_W-1:0] to_cnt, to_next;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // Bit FSM state and datapath registers.
    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            bit_state   <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            err_framing <= 1'b0;
        end else begin
            bit_state   <= bit_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shift       <= shift_next;
            byte_valid  <= byte_valid_next;
            byte_data   <= byte_data_next;
            err_framing <= err_framing_next;
        end
    end

    // Bit FSM next state: mid-bit sampling, LSB-first shift, stop-bit check.
    always_comb begin
        bit_next         = bit_state;
        cnt_next         = cnt;
        idx_next         = idx;
        shift_next       = shift;
        byte_valid_next  = 1'b0;
        byte_data_next   = byte_data;
        err_framing_next = 1'b0;
        case (bit_state)
            IDLE: begin
                if (!rx_s) begin
                    bit_next = START;
                    cnt_next = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        bit_next = DATA;
                        idx_next = '0;
                    end else begin
                        bit_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (idx == 3'd7) bit_next = STOP;
                    else             idx_next = idx + 3'd1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_valid_next = 1'b1;
                        byte_data_next  = shift;
                        bit_next        = IDLE;
                    end else begin
                        err_framing_next = 1'b1;
                        bit_next         = BREAK;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            BREAK: begin
                // A held-low line must return high before another start bit is accepted.
                if (rx_s) bit_next = IDLE;
            end
            default: bit_next = IDLE;
        endcase
    end

    // Parser FSM state, frame holding registers and command outputs.
    always_ff @(posedge sys_clock) begin
        if (!reset_n) begin
            p_state      <= P_SYNC;
            cmd_tmp      <= '0;
            data_tmp     <= '0;
            cmd_code     <= '0;
            cmd_data     <= '0;
            cmd_valid    <= 1'b0;
            err_checksum <= 1'b0;
            to_cnt       <= '0;
        end else begin
            p_state      <= p_next;
            cmd_tmp      <= cmd_tmp_next;
            data_tmp     <= data_tmp_next;
            cmd_code     <= cmd_code_next;
            cmd_data     <= cmd_data_next;
            cmd_valid    <= cmd_valid_next;
            err_checksum <= err_checksum_next;
            to_cnt       <= to_next;
        end
    end

    // Parser next state: frame sequencing, checksum, framing-error and timeout resync.
    always_comb begin
        p_next            = p_state;
        cmd_tmp_next      = cmd_tmp;
        data_tmp_next     = data_tmp;
        cmd_code_next     = cmd_code;
        cmd_data_next     = cmd_data;
        cmd_valid_next    = 1'b0;
        err_checksum_next = 1'b0;
        to_next           = to_cnt;

        // Timeout only accumulates while a frame is open and the line sits between bytes.
        if (p_state == P_SYNC || byte_valid) begin
            to_next = '0;
        end else if (bit_state == IDLE) begin
            if (to_cnt == TO_LAST) begin
                to_next = '0;
                p_next  = P_SYNC;
            end else begin
                to_next = to_cnt + 1'b1;
            end
        end

        if (err_framing && p_state != P_SYNC) begin
            p_next = P_SYNC;
        end else if (byte_valid) begin
            case (p_state)
                P_SYNC: if (byte_data == SYNC_BYTE) p_next = P_CMD;
                P_CMD: begin
                    cmd_tmp_next = byte_data;
                    p_next       = P_DATA;
                end
                P_DATA: begin
                    data_tmp_next = byte_data;
                    p_next        = P_SUM;
                end
                P_SUM: begin
                    if (byte_data == (cmd_tmp ^ data_tmp)) begin
                        cmd_code_next  = cmd_tmp;
                        cmd_data_next  = data_tmp;
                        cmd_valid_next = 1'b1;
                    end else begin
                        err_checksum_next = 1'b1;
                    end
                    p_next = P_SYNC;
                end
                default: p_next = P_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 10 clocks per bit with a 40-cycle inter-byte timeout.
module tb_uart_cmd_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       UART_RX;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_data;
    logic       err_framing;
    logic       err_checksum;

    uart_cmd_rx #(
        .CLK_FREQ    (1000),
        .BAUD        (100),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_BITS(4)
    ) dut (
        .sys_clock   (clk),
        .reset_n     (reset_n),
        .UART_RX     (UART_RX),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .cmd_valid   (cmd_valid),
        .cmd_code    (cmd_code),
        .cmd_data    (cmd_data),
        .err_framing (err_framing),
        .err_checksum(err_checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0;
    int n_bv = 0, n_cv = 0, n_fe = 0, n_ce = 0;
    int bv_cyc = 0, cv_cyc = 0, ce_cyc = 0;
    int n_cv_ce = 0, n_fe_bv = 0;
    logic [7:0] blog[$];

    always @(negedge clk) begin
        cyc++;
        if (byte_valid) begin
            n_bv++;
            bv_cyc = cyc;
            blog.push_back(byte_data);
        end
        if (cmd_valid) begin
            n_cv++;
            cv_cyc = cyc;
        end
        if (err_checksum) begin
            n_ce++;
            ce_cyc = cyc;
        end
        if (err_framing) n_fe++;
        if (cmd_valid && err_checksum) n_cv_ce++;
        if (err_framing && byte_valid) n_fe_bv++;
    end

    int s_bv, s_cv, s_fe, s_ce, s_log;

    task automatic snap();
        s_bv  = n_bv;
        s_cv  = n_cv;
        s_fe  = n_fe;
        s_ce  = n_ce;
        s_log = blog.size();
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic line(input logic v, input int n);
        UART_RX = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        line(1'b0, 10);
        for (int i = 0; i < 8; i++) line(b[i], 10);
        line(1'b1, 10);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c,
                              input logic [7:0] d, input logic [7:0] s);
        send_byte(a);
        send_byte(c);
        send_byte(d);
        send_byte(s);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bv"}, int'(byte_valid), 0);
        chk({tag, "_bd"}, int'(byte_data), 0);
        chk({tag, "_cv"}, int'(cmd_valid), 0);
        chk({tag, "_cc"}, int'(cmd_code), 0);
        chk({tag, "_cd"}, int'(cmd_data), 0);
        chk({tag, "_fe"}, int'(err_framing), 0);
        chk({tag, "_ce"}, int'(err_checksum), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        UART_RX = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;
        line(1'b1, 20);

        // 1: single byte
        snap();
        send_byte(8'h3C);
        line(1'b1, 20);
        chk("t1_bv_cnt", n_bv - s_bv, 1);
        chk("t1_byte", int'(blog[s_log]), 8'h3C);
        chk("t1_byte_data", int'(byte_data), 8'h3C);
        chk("t1_fe_cnt", n_fe - s_fe, 0);
        chk("t1_ce_cnt", n_ce - s_ce, 0);
        chk("t1_cv_cnt", n_cv - s_cv, 0);

        // 2: good frame back-to-back
        snap();
        send_frame(8'hA5, 8'h12, 8'h34, 8'h26);
        line(1'b1, 20);
        chk("t2_bv_cnt", n_bv - s_bv, 4);
        chk("t2_b0", int'(blog[s_log]), 8'hA5);
        chk("t2_b1", int'(blog[s_log + 1]), 8'h12);
        chk("t2_b2", int'(blog[s_log + 2]), 8'h34);
        chk("t2_b3", int'(blog[s_log + 3]), 8'h26);
        chk("t2_cv_cnt", n_cv - s_cv, 1);
        chk("t2_cv_lat", cv_cyc - bv_cyc, 1);
        chk("t2_code", int'(cmd_code), 8'h12);
        chk("t2_data", int'(cmd_data), 8'h34);
        chk("t2_ce_cnt", n_ce - s_ce, 0);

        // 3: bad checksum, then a good frame
        snap();
        send_frame(8'hA5, 8'h12, 8'h34, 8'h27);
        line(1'b1, 20);
        chk("t3_ce_cnt", n_ce - s_ce, 1);
        chk("t3_ce_lat", ce_cyc - bv_cyc, 1);
        chk("t3_cv_cnt", n_cv - s_cv, 0);
        chk("t3_code_keep", int'(cmd_code), 8'h12);
        chk("t3_data_keep", int'(cmd_data), 8'h34);
        snap();
        send_frame(8'hA5, 8'h01, 8'h02, 8'h03);
        line(1'b1, 20);
        chk("t3b_cv_cnt", n_cv - s_cv, 1);
        chk("t3b_code", int'(cmd_code), 8'h01);
        chk("t3b_data", int'(cmd_data), 8'h02);
        chk("t3b_ce_cnt", n_ce - s_ce, 0);

        // 4: framing error with the line held low, then recovery
        snap();
        line(1'b0, 10);
        for (int i = 0; i < 8; i++) line(i[0] ? 1'b0 : 1'b1, 10);
        line(1'b0, 30);
        chk("t4_fe_cnt", n_fe - s_fe, 1);
        chk("t4_bv_cnt", n_bv - s_bv, 0);
        line(1'b1, 20);
        chk("t4_brk_bv", n_bv - s_bv, 0);
        snap();
        send_byte(8'h0F);
        line(1'b1, 20);
        chk("t4b_bv_cnt", n_bv - s_bv, 1);
        chk("t4b_byte", int'(blog[s_log]), 8'h0F);
        chk("t4b_fe_cnt", n_fe - s_fe, 0);

        // 5: short glitch, then a frame broken by the inter-byte timeout
        snap();
        line(1'b0, 3);
        line(1'b1, 30);
        chk("t5_glitch_bv", n_bv - s_bv, 0);
        chk("t5_glitch_fe", n_fe - s_fe, 0);
        snap();
        send_byte(8'hA5);
        send_byte(8'h12);
        line(1'b1, 50);
        send_byte(8'h34);
        send_byte(8'h26);
        line(1'b1, 20);
        chk("t5_bv_cnt", n_bv - s_bv, 4);
        chk("t5_cv_cnt", n_cv - s_cv, 0);
        chk("t5_ce_cnt", n_ce - s_ce, 0);
        chk("t5_code_keep", int'(cmd_code), 8'h01);

        // 6: reset during bit 4 of the command byte, then a full frame
        send_byte(8'hA5);
        line(1'b0, 10);
        for (int i = 0; i < 4; i++) line(i == 1 ? 1'b1 : 1'b0, 10);
        line(1'b1, 5);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_all_zero("t6_rst");
        line(1'b1, 30);
        snap();
        send_frame(8'hA5, 8'h12, 8'h34, 8'h26);
        line(1'b1, 20);
        chk("t6_cv_cnt", n_cv - s_cv, 1);
        chk("t6_code", int'(cmd_code), 8'h12);
        chk("t6_data", int'(cmd_data), 8'h34);

        chk("excl_cv_ce", n_cv_ce, 0);
        chk("excl_fe_bv", n_fe_bv, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
UART receive path and command-frame parser for the host link. It is the counterpart of the FFT-magnitude UART transmit path. It deserialises 8N1 bytes from UART_RX, validates 4-byte command frames (sync, command, data, XOR checksum), and presents decoded commands to the top level, for example to gate FFT streaming or reconfigure the accelerometer. The block sits beside UARTDriver in MeasuringVibrations and runs on sys_clock.

Parameters:
CLK_FREQ, 50000000, sys_clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_BITS, 40, idle bit-times between bytes after which a partial frame is discarded

Ports:
sys_clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset (one clock; reset sampled on sys_clock rising edge)
UART_RX  in  1  asynchronous serial input, idle high
byte_valid  out  1  one-cycle pulse: byte_data holds a newly received byte
byte_data  out  8  last received byte
cmd_valid  out  1  one-cycle pulse: a frame passed checksum
cmd_code  out  8  command byte of the last valid frame
cmd_data  out  8  data byte of the last valid frame
err_framing  out  1  one-cycle pulse: stop bit sampled low
err_checksum  out  1  one-cycle pulse: frame checksum mismatch

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All outputs go to 0.
  - Both synchroniser flops go to 1.
  - Both FSMs go to IDLE / P_SYNC.
  - All counters go to 0.
  - Reset mid-byte or mid-frame discards all partial state.
- Input sync: 2-FF synchroniser on UART_RX. All logic uses the synchronised bit rx_s, so input-to-rx_s latency is 2 cycles.
- Bit FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, bit counter cleared.
  - START: count CLKS_PER_BIT/2 cycles, then sample rx_s. If 0 -> DATA, with bit index 0 and counter cleared. If 1 -> IDLE (glitch rejected, no error).
  - DATA: count CLKS_PER_BIT cycles, then sample into shift register, LSB first. After bit index 7 -> STOP.
  - STOP: count CLKS_PER_BIT cycles, then sample.
    - rx_s==1: byte_data is updated and byte_valid pulses on the next cycle; return to IDLE.
    - rx_s==0: err_framing pulses, byte is dropped, go to BREAK.
  - BREAK: stay until rx_s==1, then IDLE. This prevents a held-low line from producing 0x00 bytes.
- Parser FSM states: P_SYNC, P_CMD, P_DATA, P_SUM. It advances only on byte_valid.
  - P_SYNC: byte==SYNC_BYTE -> P_CMD; any other byte is ignored.
  - P_CMD: latch cmd_tmp -> P_DATA. A SYNC_BYTE here is treated as a command value, not a resync.
  - P_DATA: latch data_tmp -> P_SUM.
  - P_SUM:
    - byte == cmd_tmp ^ data_tmp: on the cycle after byte_valid, cmd_code/cmd_data load and cmd_valid pulses.
    - otherwise err_checksum pulses on that same cycle and cmd_code/cmd_data keep their old value.
    - Either way -> P_SYNC.
- err_framing while the parser is not in P_SYNC forces the parser to P_SYNC, with no err_checksum.
- Inter-byte timeout: a counter runs while the parser is not in P_SYNC and the bit FSM is in IDLE. It clears on every byte_valid. On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles the parser -> P_SYNC silently. The counter width must hold this value; at defaults 17360 needs 15 bits.
- Latency from stop-bit sample:
  - byte_valid: +1 cycle.
  - cmd_valid / err_checksum: +2 cycles.
- cmd_valid and err_checksum are mutually exclusive. err_framing and byte_valid are mutually exclusive.
- Back-to-back bytes: the next start bit may begin the cycle after the stop sample. IDLE detects it with no dead time beyond the FSM transition.
- Outputs are registered; no combinational path from UART_RX to any output.

Test Plan:
(Bench uses CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10; TIMEOUT_BITS=4.)
1. Drive byte 0x3C at 10 clk/bit -> exactly one byte_valid pulse, byte_data=0x3C, no err pulses.
2. Frame A5,12,34,26 back-to-back -> four byte_valid pulses; cmd_valid one cycle after the 4th byte_valid; cmd_code=0x12, cmd_data=0x34.
3. Frame A5,12,34,27 -> err_checksum pulse, no cmd_valid, cmd_code/cmd_data unchanged from scenario 2. Then A5,01,02,03 -> cmd_valid with 0x01/0x02.
4. Byte 0x55 with stop bit held low for 30 clk -> err_framing pulse, no byte_valid. Line stays in BREAK with no spurious bytes until high. A following 0x0F is received correctly.
5. Low glitch of 3 clk on idle line -> no byte_valid, no err pulses. Send A5,12, idle 50 clk, then 34,26 -> no cmd_valid (timeout resynced; 34 ignored as non-sync).
6. Assert reset_n=0 for one cycle during bit 4 of the command byte -> all outputs 0 next cycle. A subsequent full frame A5,12,34,26 decodes to cmd_valid with 0x12/0x34.
